// File: rtl/bias_weight_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bias_weight_pkg : state and mode encodings shared by the scheduler
// Revision 1.0
// ------------------------------------------------------------------
package bias_weight_pkg;

  typedef enum logic [1:0] {
    INFER = 2'd0,
    FWD   = 2'd1,
    BWD   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_BWD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bias_weight_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// bias_weight_stage : one-entry valid/ready register slice for {mode, data}
// Revision 1.0
// ------------------------------------------------------------------
module bias_weight_stage
  import bias_weight_pkg::*;
#(
  parameter int WDATA = 64
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  input  logic             iMode,
  input  logic [WDATA-1:0] iData,
  input  logic             iReady,
  output logic             oValid,
  output logic             oMode,
  output logic [WDATA-1:0] oData,
  output logic             oSlot
);

  logic             rValid;
  logic             rMode;
  logic [WDATA-1:0] rData;

  // The register may take a new beat when empty or being drained this cycle.
  assign oSlot = !rValid || iReady;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rValid <= 1'b0;
      rMode  <= MODE_FWD;
      rData  <= '0;
    end else if (oSlot) begin
      rValid <= iValid;
      if (iValid) begin
        rMode <= iMode;
        rData <= iData;
      end
    end
  end

  assign oValid = rValid;
  assign oMode  = rMode;
  assign oData  = rData;

endmodule
`default_nettype wire

// File: rtl/bias_weight_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// bias_weight_scheduler : orders FW/BW batches into BiasWeight, then pulses update
// Revision 1.0
// ------------------------------------------------------------------
module bias_weight_scheduler
  import bias_weight_pkg::*;
#(
  parameter int WDATA = 64,
  parameter int BATCH = 4,
  parameter int WB    = $clog2(BATCH + 1)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iTrain,
  input  logic             iValid_FW,
  output logic             oReady_FW,
  input  logic [WDATA-1:0] iData_FW,
  input  logic             iValid_BW,
  output logic             oReady_BW,
  input  logic [WDATA-1:0] iData_BW,
  output logic             oValid_BS,
  input  logic             iReady_BS,
  output logic [WDATA-1:0] oData_BS,
  output logic             oMode,
  output logic [WB-1:0]    oBatchCnt,
  output logic             oUpdate,
  output logic             oBusy
);

  localparam logic [WB-1:0] LAST_BEAT = WB'(BATCH - 1);

  state_t          rState;
  logic [WB-1:0]   rBatchCnt;
  logic            rUpdate;

  logic            wSlot;
  logic            wSwitchFwd;
  logic            wAccFw;
  logic            wAccBw;
  logic            wInValid;
  logic            wInMode;
  logic [WDATA-1:0] wInData;

  // Leaving training is only allowed on a batch boundary.
  assign wSwitchFwd = (rBatchCnt == '0) && !iTrain;

  assign oReady_FW = wSlot && (((rState == INFER) && !iTrain) ||
                               ((rState == FWD) && !wSwitchFwd));
  assign oReady_BW = wSlot && (rState == BWD);

  assign wAccFw   = oReady_FW && iValid_FW;
  assign wAccBw   = oReady_BW && iValid_BW;
  assign wInValid = wAccFw || wAccBw;
  assign wInMode  = wAccBw ? MODE_BWD : MODE_FWD;
  assign wInData  = wAccBw ? iData_BW : iData_FW;

  bias_weight_stage #(
    .WDATA (WDATA)
  ) u_stage (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iValid (wInValid),
    .iMode  (wInMode),
    .iData  (wInData),
    .iReady (iReady_BS),
    .oValid (oValid_BS),
    .oMode  (oMode),
    .oData  (oData_BS),
    .oSlot  (wSlot)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rState    <= INFER;
      rBatchCnt <= '0;
      rUpdate   <= 1'b0;
    end else begin
      rUpdate <= 1'b0;
      case (rState)
        INFER: begin
          if (iTrain) rState <= FWD;
        end
        FWD: begin
          if (wAccFw) begin
            if (rBatchCnt == LAST_BEAT) begin
              rState    <= BWD;
              rBatchCnt <= '0;
            end else begin
              rBatchCnt <= rBatchCnt + WB'(1);
            end
          end else if (wSwitchFwd) begin
            rState <= INFER;
          end
        end
        BWD: begin
          if (wAccBw) begin
            if (rBatchCnt == LAST_BEAT) begin
              rState    <= DRAIN;
              rBatchCnt <= '0;
            end else begin
              rBatchCnt <= rBatchCnt + WB'(1);
            end
          end
        end
        DRAIN: begin
          // Update only once the last backward beat has left the output register.
          if (!oValid_BS) begin
            rUpdate <= 1'b1;
            rState  <= iTrain ? FWD : INFER;
          end
        end
        default: rState <= INFER;
      endcase
    end
  end

  assign oBatchCnt = rBatchCnt;
  assign oUpdate   = rUpdate;
  assign oBusy     = (rState != INFER) || oValid_BS;

endmodule
`default_nettype wire

// File: tb/tb_bias_weight_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bias_weight_scheduler : BATCH=4 and BATCH=1 instances against a batch-level model
// Revision 1.0
// ------------------------------------------------------------------
module tb_bias_weight_scheduler;

  localparam int WDATA = 8;
  localparam int NI    = 2;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic             iTrain;
  logic             iValid_FW;
  logic             iValid_BW;
  logic             iReady_BS;
  logic [WDATA-1:0] iData_FW;
  logic [WDATA-1:0] iData_BW;

  logic             oReady_FW [NI];
  logic             oReady_BW [NI];
  logic             oValid_BS [NI];
  logic             oMode     [NI];
  logic             oUpdate   [NI];
  logic             oBusy     [NI];
  logic [WDATA-1:0] oData_BS  [NI];
  logic [2:0]       oBatchCnt0;
  logic [0:0]       oBatchCnt1;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  bias_weight_scheduler #(.WDATA(WDATA), .BATCH(4)) dut0 (
    .iCLK(iCLK), .iRST(iRST), .iTrain(iTrain),
    .iValid_FW(iValid_FW), .oReady_FW(oReady_FW[0]), .iData_FW(iData_FW),
    .iValid_BW(iValid_BW), .oReady_BW(oReady_BW[0]), .iData_BW(iData_BW),
    .oValid_BS(oValid_BS[0]), .iReady_BS(iReady_BS), .oData_BS(oData_BS[0]),
    .oMode(oMode[0]), .oBatchCnt(oBatchCnt0), .oUpdate(oUpdate[0]), .oBusy(oBusy[0])
  );

  bias_weight_scheduler #(.WDATA(WDATA), .BATCH(1)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iTrain(iTrain),
    .iValid_FW(iValid_FW), .oReady_FW(oReady_FW[1]), .iData_FW(iData_FW),
    .iValid_BW(iValid_BW), .oReady_BW(oReady_BW[1]), .iData_BW(iData_BW),
    .oValid_BS(oValid_BS[1]), .iReady_BS(iReady_BS), .oData_BS(oData_BS[1]),
    .oMode(oMode[1]), .oBatchCnt(oBatchCnt1), .oUpdate(oUpdate[1]), .oBusy(oBusy[1])
  );

  // Batch-level reference: a training round is nFw forward beats then nBw backward
  // beats, then an update once the output register is empty.
  int   batchOf [NI] = '{4, 1};
  bit   mTrain  [NI];
  int   nFw     [NI];
  int   nBw     [NI];
  bit   qV      [NI];
  bit   qM      [NI];
  logic [WDATA-1:0] qD [NI];
  bit   mUpd    [NI];
  bit   eRf     [NI];
  bit   eRb     [NI];

  typedef struct {
    logic tr; logic vf; logic [7:0] df; logic vb; logic [7:0] db; logic rdy;
    logic eV; logic [7:0] eD; logic eM; int eCnt; logic eRf; logic eRb; logic eUpd; logic eBusy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dutCnt(input int i);
    return (i == 0) ? int'(oBatchCnt0) : int'(oBatchCnt1);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mTrain[i] = 0; nFw[i] = 0; nBw[i] = 0; qV[i] = 0; qM[i] = 0; qD[i] = '0; mUpd[i] = 0;
    end
  endtask

  task automatic checkModel();
    for (int i = 0; i < NI; i++) begin
      bit slot;
      int b;
      int cnt;
      b    = batchOf[i];
      slot = !qV[i] || iReady_BS;
      if (!mTrain[i]) eRf[i] = slot && !iTrain;
      else            eRf[i] = slot && (nFw[i] < b) && !(nFw[i] == 0 && !iTrain);
      eRb[i] = slot && mTrain[i] && (nFw[i] == b) && (nBw[i] < b);
      cnt = !mTrain[i] ? 0 : (nFw[i] < b) ? nFw[i] : (nBw[i] < b) ? nBw[i] : 0;
      chk($sformatf("readyFw[%0d]", i), oReady_FW[i], eRf[i]);
      chk($sformatf("readyBw[%0d]", i), oReady_BW[i], eRb[i]);
      chk($sformatf("validBs[%0d]", i), oValid_BS[i], qV[i]);
      chk($sformatf("batchCnt[%0d]", i), dutCnt(i), cnt);
      chk($sformatf("update[%0d]", i), oUpdate[i], mUpd[i]);
      chk($sformatf("busy[%0d]", i), oBusy[i], int'(mTrain[i] || qV[i]));
      if (qV[i]) begin
        chk($sformatf("dataBs[%0d]", i), oData_BS[i], qD[i]);
        chk($sformatf("mode[%0d]", i), oMode[i], qM[i]);
      end
    end
  endtask

  task automatic stepModel();
    for (int i = 0; i < NI; i++) begin
      bit slot, accF, accB, wasValid;
      int b;
      b        = batchOf[i];
      slot     = !qV[i] || iReady_BS;
      accF     = eRf[i] && iValid_FW;
      accB     = eRb[i] && iValid_BW;
      wasValid = qV[i];
      mUpd[i]  = 0;
      if (slot) begin
        qV[i] = accF || accB;
        if (accF)      begin qM[i] = 0; qD[i] = iData_FW; end
        else if (accB) begin qM[i] = 1; qD[i] = iData_BW; end
      end
      if (!mTrain[i]) begin
        if (iTrain) begin mTrain[i] = 1; nFw[i] = 0; nBw[i] = 0; end
      end else if (nFw[i] < b) begin
        if (accF) nFw[i]++;
        else if (nFw[i] == 0 && !iTrain) mTrain[i] = 0;
      end else if (nBw[i] < b) begin
        if (accB) nBw[i]++;
      end else if (!wasValid) begin
        mUpd[i] = 1; mTrain[i] = iTrain; nFw[i] = 0; nBw[i] = 0;
      end
    end
  endtask

  task automatic finishCycle();
    checkModel();
    stepModel();
    @(posedge iCLK);
    #1;
  endtask

  task automatic cycle();
    #1;
    finishCycle();
  endtask

  task automatic randData();
    iData_FW = WDATA'($urandom);
    iData_BW = WDATA'($urandom);
  endtask

  task automatic addV(input logic tr, vf, input logic [7:0] df, input logic vb,
                      input logic [7:0] db, input logic rdy, input logic eV,
                      input logic [7:0] eD, input logic eM, input int eCnt,
                      input logic eRf_, eRb_, eUpd, eBusy);
    vec_t v;
    v.tr = tr; v.vf = vf; v.df = df; v.vb = vb; v.db = db; v.rdy = rdy;
    v.eV = eV; v.eD = eD; v.eM = eM; v.eCnt = eCnt;
    v.eRf = eRf_; v.eRb = eRb_; v.eUpd = eUpd; v.eBusy = eBusy;
    tbl.push_back(v);
  endtask

  task automatic runVec(input int k, input vec_t v);
    iTrain = v.tr; iValid_FW = v.vf; iData_FW = v.df;
    iValid_BW = v.vb; iData_BW = v.db; iReady_BS = v.rdy;
    #1;
    chk($sformatf("vec%0d valid", k), oValid_BS[0], v.eV);
    if (v.eV) begin
      chk($sformatf("vec%0d data", k), oData_BS[0], v.eD);
      chk($sformatf("vec%0d mode", k), oMode[0], v.eM);
    end
    chk($sformatf("vec%0d cnt", k), oBatchCnt0, v.eCnt);
    chk($sformatf("vec%0d readyFw", k), oReady_FW[0], v.eRf);
    chk($sformatf("vec%0d readyBw", k), oReady_BW[0], v.eRb);
    chk($sformatf("vec%0d update", k), oUpdate[0], v.eUpd);
    chk($sformatf("vec%0d busy", k), oBusy[0], v.eBusy);
    finishCycle();
  endtask

  task automatic applyReset();
    iRST = 1; iTrain = 0; iValid_FW = 0; iValid_BW = 0; iReady_BS = 1;
    iData_FW = '0; iData_BW = '0;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    iRST = 0;
    modelReset();
  endtask

  // Finish any open round, leave both instances idle in inference.
  task automatic settle();
    iTrain = 0; iValid_FW = 1; iValid_BW = 1; iReady_BS = 1;
    for (int g = 0; g < 80 && (mTrain[0] || mTrain[1]); g++) begin
      randData();
      cycle();
    end
    chk("settle idle", int'(mTrain[0] || mTrain[1]), 0);
    iValid_FW = 0; iValid_BW = 0;
    cycle();
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prevMode, havePrev;
    int nUpd, nBeats;

    applyReset();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst valid[%0d]", i), oValid_BS[i], 0);
      chk($sformatf("rst data[%0d]", i), oData_BS[i], 0);
      chk($sformatf("rst mode[%0d]", i), oMode[i], 0);
      chk($sformatf("rst cnt[%0d]", i), dutCnt(i), 0);
      chk($sformatf("rst update[%0d]", i), oUpdate[i], 0);
      chk($sformatf("rst busy[%0d]", i), oBusy[i], 0);
    end

    //   tr vf df     vb db     rdy | eV eD     eM cnt rf rb upd busy
    addV(0, 1, 8'h11, 0, 8'h00, 1,   0, 8'h00, 0, 0,  1, 0, 0,  0);
    addV(0, 1, 8'h22, 0, 8'h00, 1,   1, 8'h11, 0, 0,  1, 0, 0,  1);
    addV(0, 1, 8'h33, 0, 8'h00, 1,   1, 8'h22, 0, 0,  1, 0, 0,  1);
    addV(0, 0, 8'h00, 0, 8'h00, 1,   1, 8'h33, 0, 0,  1, 0, 0,  1);
    addV(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0,  1, 0, 0,  0);
    addV(1, 1, 8'h01, 1, 8'h05, 1,   0, 8'h00, 0, 0,  0, 0, 0,  0);
    addV(1, 1, 8'h01, 1, 8'h05, 1,   0, 8'h00, 0, 0,  1, 0, 0,  1);
    addV(1, 1, 8'h02, 1, 8'h05, 1,   1, 8'h01, 0, 1,  1, 0, 0,  1);
    addV(1, 1, 8'h03, 1, 8'h05, 1,   1, 8'h02, 0, 2,  1, 0, 0,  1);
    addV(1, 1, 8'h04, 1, 8'h05, 1,   1, 8'h03, 0, 3,  1, 0, 0,  1);
    addV(1, 1, 8'h04, 1, 8'h05, 1,   1, 8'h04, 0, 0,  0, 1, 0,  1);
    addV(1, 1, 8'h04, 1, 8'h06, 1,   1, 8'h05, 1, 1,  0, 1, 0,  1);
    addV(1, 1, 8'h04, 1, 8'h07, 1,   1, 8'h06, 1, 2,  0, 1, 0,  1);
    addV(1, 1, 8'h04, 1, 8'h08, 1,   1, 8'h07, 1, 3,  0, 1, 0,  1);
    addV(1, 0, 8'h00, 0, 8'h00, 1,   1, 8'h08, 1, 0,  0, 0, 0,  1);
    addV(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0,  0, 0, 0,  1);
    addV(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0,  1, 0, 1,  0);
    addV(0, 0, 8'h00, 0, 8'h00, 1,   0, 8'h00, 0, 0,  1, 0, 0,  0);
    foreach (tbl[k]) runVec(k, tbl[k]);
    settle();

    // Backpressure in the middle of a forward phase.
    iTrain = 1; iValid_FW = 1; iValid_BW = 0; iReady_BS = 1;
    for (int g = 0; g < 20 && nFw[0] < 2; g++) begin randData(); cycle(); end
    chk("bp reach fw2", nFw[0], 2);
    iReady_BS = 0;
    for (int s = 0; s < 3; s++) begin
      randData();
      #1;
      chk("bp stall readyFw", oReady_FW[0], 0);
      chk("bp stall valid", oValid_BS[0], 1);
      chk("bp held data", oData_BS[0], qD[0]);
      finishCycle();
    end
    iReady_BS = 1;
    for (int g = 0; g < 20 && nFw[0] < 4; g++) begin randData(); cycle(); end
    chk("bp resume fw4", nFw[0], 4);
    settle();

    // Training dropped after two forward beats: the round still completes.
    iTrain = 1; iValid_FW = 1; iValid_BW = 1; iReady_BS = 1;
    for (int g = 0; g < 20 && nFw[0] < 2; g++) begin randData(); cycle(); end
    chk("drop reach fw2", nFw[0], 2);
    iTrain = 0;
    begin
      bit seen;
      seen = 0;
      for (int g = 0; g < 40; g++) begin
        randData();
        #1;
        if (oUpdate[0]) begin seen = 1; break; end
        finishCycle();
      end
      chk("drop update seen", seen, 1);
      chk("drop back to infer busy", oBusy[0], 0);
      chk("drop back to infer readyFw", oReady_FW[0], 1);
      finishCycle();
    end
    settle();

    // Reset in the backward phase with a held beat.
    iTrain = 1; iValid_FW = 1; iValid_BW = 1; iReady_BS = 1;
    for (int g = 0; g < 30 && !(nFw[0] == 4 && nBw[0] == 2); g++) begin randData(); cycle(); end
    iReady_BS = 0;
    #1;
    chk("rstmid cnt before", oBatchCnt0, 2);
    chk("rstmid held before", oValid_BS[0], 1);
    iRST = 1;
    @(posedge iCLK); #1;
    iRST = 0; iTrain = 0; iValid_FW = 0; iValid_BW = 0; iReady_BS = 1;
    modelReset();
    chk("rstmid valid", oValid_BS[0], 0);
    chk("rstmid cnt", oBatchCnt0, 0);
    chk("rstmid busy", oBusy[0], 0);
    chk("rstmid update", oUpdate[0], 0);
    for (int g = 0; g < 3; g++) cycle();

    // Randomized traffic checked cycle by cycle against the model.
    for (int g = 0; g < 2000; g++) begin
      if ($urandom_range(0, 19) == 0) iTrain = ~iTrain;
      iValid_FW = ($urandom_range(0, 9) < 7);
      iValid_BW = ($urandom_range(0, 9) < 7);
      iReady_BS = ($urandom_range(0, 3) != 0);
      randData();
      cycle();
    end
    settle();

    // BATCH=1 instance: strict FW/BW alternation with an update per round.
    applyReset();
    iTrain = 1; iValid_FW = 1; iValid_BW = 1; iReady_BS = 1;
    prevMode = 0; havePrev = 0; nUpd = 0; nBeats = 0;
    for (int g = 0; g < 30; g++) begin
      randData();
      #1;
      if (oValid_BS[1]) begin
        if (havePrev) chk("b1 alternate", oMode[1], int'(!prevMode));
        prevMode = oMode[1];
        havePrev = 1;
        nBeats++;
      end
      if (oUpdate[1]) nUpd++;
      finishCycle();
    end
    chk("b1 beats seen", int'(nBeats >= 10), 1);
    chk("b1 updates per pair", int'(nUpd >= nBeats / 2 - 1 && nUpd <= nBeats / 2 + 1), 1);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
